// File: rtl/exc_ctrl.sv
// Writeback exception/ERTN commit controller: prioritises exception flags,
// pulses the CSR commit strobes, flushes younger stages and holds a redirect.
module exc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ws_valid,
  input  logic [31:0]      ws_pc,
  input  logic [31:0]      ws_vaddr,
  input  logic [5:0]       ws_ex_flags,
  input  logic             ws_ertn,
  input  logic [31:0]      ex_entry,
  input  logic [31:0]      ertn_entry,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_vaddr,
  output logic             ertn_flush,
  output logic             ws_commit,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] ex_cnt
);

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  state_t            state_r;
  logic [31:0]       redirect_pc_r;
  logic [CNT_W-1:0]  ex_cnt_r;
  logic              idle_s;
  logic              any_ex_s;
  logic              trig_ex_s;
  logic              trig_ertn_s;

  // Flag order is {ale, brk, sys, ine, adef, int}; lowest bit has highest priority.
  function automatic logic [5:0] ecode_of(input logic [5:0] flags);
    logic [5:0] code;
    if (flags[0]) begin
      code = 6'h00;
    end else if (flags[1]) begin
      code = 6'h08;
    end else if (flags[2]) begin
      code = 6'h0D;
    end else if (flags[3]) begin
      code = 6'h0B;
    end else if (flags[4]) begin
      code = 6'h0C;
    end else if (flags[5]) begin
      code = 6'h09;
    end else begin
      code = 6'h00;
    end
    return code;
  endfunction

  // Trigger decode; WB inputs are only honoured while idle.
  always_comb begin
    idle_s      = (state_r == IDLE);
    any_ex_s    = |ws_ex_flags;
    trig_ex_s   = idle_s & ws_valid & any_ex_s;
    trig_ertn_s = idle_s & ws_valid & ws_ertn & ~any_ex_s;
  end

  assign wb_ex          = trig_ex_s;
  assign ertn_flush     = trig_ertn_s;
  assign wb_ecode       = ecode_of(ws_ex_flags);
  assign wb_esubcode    = 9'd0;
  assign wb_pc          = ws_pc;
  assign wb_vaddr       = ws_vaddr;
  assign ws_commit      = idle_s & ws_valid & ~any_ex_s & ~ws_ertn;
  assign flush          = trig_ex_s | trig_ertn_s | ~idle_s;
  assign redirect_valid = ~idle_s;
  assign redirect_pc    = redirect_pc_r;
  assign ex_cnt         = ex_cnt_r;

  // Redirect FSM; entry addresses are captured before the CSR update lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      redirect_pc_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_ex_s) begin
            state_r       <= REDIR;
            redirect_pc_r <= ex_entry;
          end else if (trig_ertn_s) begin
            state_r       <= REDIR;
            redirect_pc_r <= ertn_entry;
          end else begin
            state_r       <= IDLE;
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= REDIR;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Saturating debug count of committed exceptions.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_cnt_r <= {CNT_W{1'b0}};
    end else if (trig_ex_s && (ex_cnt_r != {CNT_W{1'b1}})) begin
      ex_cnt_r <= ex_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ex_cnt_r <= ex_cnt_r;
    end
  end

endmodule
